oled_hex_monitor: RTL
=====================

// Module: oled_hex_monitor
// PURPOSE
//  Parametrised debug-status front end for the 128x32 OLED character controller (OLEDCtrl-style interface).
//  Renders a fixed title row plus NCH hex-formatted channels (up to CH_W bits each) into the 4x16 text grid.
//  Sequences controller power-up/down and refreshes periodically. Optional change-only refresh and leading-zero blanking.
//  Sits in the SoC next to the controller; channel inputs are free-running debug buses (address, data, PC, ...).
// PARAMETERS
//  NCH         3            channels shown, rows 1..NCH (1..3)
//  CH_W        32           bits per channel, multiple of 4, 4..52 (DIG = CH_W/4 digits)
//  REFRESH     5000000      clk cycles between refresh ticks (>=2)
//  CHANGE_ONLY 0            1: skip a frame whose snapshot equals the last drawn snapshot
//  LZ_BLANK    0            1: leading zero digits shown as ' ' (least significant digit always shown)
//  TITLE       "N4V SoC Status  "  128-bit, 16 ASCII chars, row 0, leftmost char in bits [127:120]
//  LABELS      "ADP"        NCH*8-bit, label char per channel, channel 0 in the most significant byte
// PORTS
//  clk              in   1          system clock
//  rst              in   1          synchronous reset, active-low (0 = reset)
//  en               in   1          1 = display on / keep running, 0 = power display down
//  ch_data          in   NCH*CH_W   channel values, channel k in [k*CH_W +: CH_W]
//  write_start      out  1          one-cycle pulse: write character to controller
//  write_ascii_data out  8          character code, valid with write_start
//  write_base_addr  out  9          {row[1:0], col[3:0], 3'b0}, valid with write_start
//  write_ready      in   1          controller idle for character writes
//  update_start     out  1          one-cycle pulse: push memory to panel
//  update_clear     out  1          held 0 (never clear)
//  update_ready     in   1          update finished / controller idle
//  disp_on_start    out  1          one-cycle pulse: power-up sequence
//  disp_on_ready    in   1          power-up available/finished
//  disp_off_start   out  1          one-cycle pulse: power-down sequence
//  disp_off_ready   in   1          power-down available/finished
//  busy             out  1          1 whenever state != OFF and != IDLE
//  frame_cnt        out  16         frames pushed to panel, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0, any state): state OFF; all *_start, update_clear, busy = 0; write_base_addr = 0, write_ascii_data = 8'h20;
//   frame_cnt = 0; refresh counter = 0; pending tick = 0; last snapshot = all ones; valid flag = 0. Reset aborts any frame.
//  Refresh counter: counts 0..REFRESH-1 and wraps. tick = (count == REFRESH-1). A tick while not IDLE sets pending; IDLE consumes it.
//  Handshake: each *_start is a 1-cycle pulse, issued only when its ready = 1. The cycle after the pulse is ignored.
//   From the 2nd cycle after the pulse, the FSM waits for ready = 1.
//  FSM:
//   OFF:        en & disp_on_ready -> pulse disp_on_start, go PWRUP_WAIT
//   PWRUP_WAIT: disp_on_ready -> clear valid, set pending (first frame immediate), go IDLE
//   IDLE:       if !en & disp_off_ready -> pulse disp_off_start, go PWRDN_WAIT
//               else if (tick|pending):
//                 clear pending; latch ch_data into snapshot (one cycle, SNAP)
//                 if CHANGE_ONLY & valid & snapshot==last: back to IDLE, no writes
//                 else go WRITE with addr = 0
//   WRITE:      when write_ready: pulse write_start with char(addr), go WRITE_WAIT
//   WRITE_WAIT: write_ready -> if addr==9'h1F8: go UPDATE, else addr += 8, go WRITE
//   UPDATE:     when update_ready: pulse update_start, go UPDATE_WAIT
//   UPDATE_WAIT: update_ready -> last = snapshot, valid = 1, frame_cnt++, go IDLE
//   PWRDN_WAIT: disp_off_ready -> go OFF
//  en deasserted mid-frame: the frame completes (through UPDATE_WAIT); power-down happens in IDLE.
//  Character map (row = addr[8:7], col = addr[6:3]):
//   row 0: TITLE byte col.
//   row r in 1..NCH, k = r-1:
//     col0 = LABELS byte k; col1 = ':'; col2 = ' '
//     cols 3..3+DIG-1 = hex digit, MS digit first, uppercase '0'-'9','A'-'F'
//     remaining cols ' '
//   rows > NCH: all ' '.
//   LZ_BLANK: a digit is blank iff it and every more-significant digit are 0, and it is not the LS digit.
//  Digits are taken only from the snapshot; ch_data changes during a frame never tear the display.
// TESTING
//  1 Power-up: rst released, en=1, disp_on_ready=1 -> exactly one disp_on_start pulse, then a frame of 64 writes and one update_start without waiting for tick.
//  2 Frame content: NCH=3, CH_W=32, ch0=32'h0012ABEF -> row1 chars "A: 0012ABEF    "; addr sequence 0x000,0x008..0x1F8; frame_cnt=1.
//  3 LZ_BLANK=1: ch0=32'h0000_0000 -> "A:        0"; ch1=32'h0000_0A00 -> "D:      A00".
//  4 CHANGE_ONLY=1, REFRESH=100: constant ch_data -> only the first frame is written; change ch2 -> the next tick writes a frame.
//  5 en 1->0 mid-frame (after write 20) -> remaining 44 writes + update complete, then disp_off_start, OFF; busy=0.
//  6 rst=0 during WRITE_WAIT -> next cycle all outputs at reset values; the controller stub sees no further pulses.

Source files
------------

// File: rtl/oled_hex_monitor_if.sv
// Character/update/power handshake bundle between the hex monitor and the OLED controller.
interface oled_hex_monitor_if;
  logic       write_start;
  logic [7:0] write_ascii_data;
  logic [8:0] write_base_addr;
  logic       write_ready;
  logic       update_start;
  logic       update_clear;
  logic       update_ready;
  logic       disp_on_start;
  logic       disp_on_ready;
  logic       disp_off_start;
  logic       disp_off_ready;

  modport master (
    output write_start, write_ascii_data, write_base_addr, update_start, update_clear,
           disp_on_start, disp_off_start,
    input  write_ready, update_ready, disp_on_ready, disp_off_ready
  );

  modport slave (
    input  write_start, write_ascii_data, write_base_addr, update_start, update_clear,
           disp_on_start, disp_off_start,
    output write_ready, update_ready, disp_on_ready, disp_off_ready
  );
endinterface

// File: rtl/oled_hex_monitor.sv
// Debug status front end: draws a title row plus NCH hex channels into the 4x16 OLED text grid,
// sequences controller power-up/down and refreshes on a fixed period.
module oled_hex_monitor #(
  parameter int unsigned      NCH         = 3,
  parameter int unsigned      CH_W        = 32,
  parameter int unsigned      REFRESH     = 5000000,
  parameter bit               CHANGE_ONLY = 1'b0,
  parameter bit               LZ_BLANK    = 1'b0,
  parameter logic [127:0]     TITLE       = "N4V SoC Status  ",
  parameter logic [NCH*8-1:0] LABELS      = "ADP"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH*CH_W-1:0]   ch_data,
  oled_hex_monitor_if.master    oled,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  localparam int unsigned DIG = CH_W / 4;
  localparam int unsigned CW  = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  typedef enum logic [3:0] {
    StOff, StPwrupWait, StIdle, StSnap, StWrite, StWriteWait, StUpdate, StUpdateWait, StPwrdnWait
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                pend_q;
  logic                valid_q;
  logic [1:0]          skip_q;
  logic [8:0]          addr_q;
  logic [NCH*CH_W-1:0] snap_q;
  logic [NCH*CH_W-1:0] last_q;
  logic                tick;
  logic [7:0]          chr;
  logic [CH_W-1:0]     val;
  logic [3:0]          nib;
  int unsigned         r, c, d;

  assign tick              = (cnt_q == CW'(REFRESH - 1));
  assign busy              = (state_q != StOff) && (state_q != StIdle);
  assign oled.update_clear = 1'b0;

  // Character for the grid cell at addr_q, digits drawn from the frozen snapshot only.
  always_comb begin
    r   = 32'(addr_q[8:7]);
    c   = 32'(addr_q[6:3]);
    chr = 8'h20;
    val = '0;
    nib = '0;
    d   = 0;
    if (r == 0) begin
      chr = TITLE[8*(15-c) +: 8];
    end else if (r <= NCH) begin
      val = snap_q[(r-1)*CH_W +: CH_W];
      if (c == 0) begin
        chr = LABELS[8*(NCH-r) +: 8];
      end else if (c == 1) begin
        chr = 8'h3A;
      end else if (c >= 3 && c < 3 + DIG) begin
        d   = c - 3;
        nib = val[4*(DIG-1-d) +: 4];
        if (LZ_BLANK && ((val >> (4*(DIG-1-d))) == '0) && (d != DIG - 1)) chr = 8'h20;
        else if (nib < 4'd10) chr = {4'h3, nib};
        else chr = 8'h37 + {4'h0, nib};
      end
    end
  end

  // skip_q masks the pulse cycle and the one after it before ready is trusted again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q               <= StOff;
      oled.write_start      <= 1'b0;
      oled.update_start     <= 1'b0;
      oled.disp_on_start    <= 1'b0;
      oled.disp_off_start   <= 1'b0;
      oled.write_ascii_data <= 8'h20;
      oled.write_base_addr  <= '0;
      frame_cnt             <= '0;
      cnt_q                 <= '0;
      pend_q                <= 1'b0;
      valid_q               <= 1'b0;
      last_q                <= '1;
      snap_q                <= '0;
      addr_q                <= '0;
      skip_q                <= '0;
    end else begin
      oled.write_start    <= 1'b0;
      oled.update_start   <= 1'b0;
      oled.disp_on_start  <= 1'b0;
      oled.disp_off_start <= 1'b0;
      cnt_q               <= tick ? '0 : cnt_q + CW'(1);
      if (tick && state_q != StIdle) pend_q <= 1'b1;
      if (skip_q != 2'd0) skip_q <= skip_q - 2'd1;
      unique case (state_q)
        StOff: if (en && oled.disp_on_ready) begin
          oled.disp_on_start <= 1'b1;
          skip_q             <= 2'd2;
          state_q            <= StPwrupWait;
        end
        StPwrupWait: if (skip_q == 2'd0 && oled.disp_on_ready) begin
          valid_q <= 1'b0;
          pend_q  <= 1'b1;
          state_q <= StIdle;
        end
        StIdle: begin
          if (!en && oled.disp_off_ready) begin
            oled.disp_off_start <= 1'b1;
            skip_q              <= 2'd2;
            state_q             <= StPwrdnWait;
          end else if (tick || pend_q) begin
            pend_q  <= 1'b0;
            snap_q  <= ch_data;
            state_q <= StSnap;
          end
        end
        StSnap: begin
          if (CHANGE_ONLY && valid_q && snap_q == last_q) begin
            state_q <= StIdle;
          end else begin
            addr_q  <= '0;
            state_q <= StWrite;
          end
        end
        StWrite: if (oled.write_ready) begin
          oled.write_start      <= 1'b1;
          oled.write_ascii_data <= chr;
          oled.write_base_addr  <= addr_q;
          skip_q                <= 2'd2;
          state_q               <= StWriteWait;
        end
        StWriteWait: if (skip_q == 2'd0 && oled.write_ready) begin
          if (addr_q == 9'h1F8) begin
            state_q <= StUpdate;
          end else begin
            addr_q  <= addr_q + 9'd8;
            state_q <= StWrite;
          end
        end
        StUpdate: if (oled.update_ready) begin
          oled.update_start <= 1'b1;
          skip_q            <= 2'd2;
          state_q           <= StUpdateWait;
        end
        StUpdateWait: if (skip_q == 2'd0 && oled.update_ready) begin
          last_q    <= snap_q;
          valid_q   <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
          state_q   <= StIdle;
        end
        StPwrdnWait: if (skip_q == 2'd0 && oled.disp_off_ready) state_q <= StOff;
        default: state_q <= StOff;
      endcase
    end
  end
endmodule
